// File: rtl/sub_bytes.sv
// AES-128 SubBytes stage: the S-box is applied to each of the 16 state bytes in place.
// Latency 1 cycle: OUT_valid/OUT_state are registered copies of the IN_valid-qualified result.
// No backpressure: accepts one state per cycle; the state is held while IN_valid is low.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (clears OUT_valid and OUT_state)
//   IN_valid  IN_state carries a state this cycle
//   IN_state  128-bit state, byte k = IN_state[8k+7:8k]
//   IN_inv    (SUBBYTES_INV_EN builds only) 1 = InvSubBytes, 0 = SubBytes
//   OUT_valid registered: OUT_state holds a fresh result
//   OUT_state registered substituted state, byte positions preserved
//
// Build option: define SUBBYTES_INV_EN to add the IN_inv port and the inverse S-box.

module sub_bytes (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         IN_valid,
   input  logic [127:0] IN_state,
`ifdef SUBBYTES_INV_EN
   input  logic         IN_inv,
`endif
   output logic         OUT_valid,
   output logic [127:0] OUT_state
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^255 = 1 for a != 0); 0^254 = 0 gives the
   // required 00 -> 00 mapping for free.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);   // a^(2^i)
         r  = gf_mul(r, sq);    // accumulates a^(2+4+...+128) = a^254
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
      logic [7:0] x;
      x = gf_inv(b);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

`ifdef SUBBYTES_INV_EN
   // Inverse affine first, then the field inverse.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] y;
      y = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      return gf_inv(y);
   endfunction
`endif

   logic [127:0] w_sub;
   logic         r_valid;
   logic [127:0] r_state;

   // 16 independent byte lanes.
   always_comb begin
      w_sub = '0;
      for (int k = 0; k < 16; k++) begin
`ifdef SUBBYTES_INV_EN
         w_sub[8*k +: 8] = IN_inv ? inv_sbox(IN_state[8*k +: 8])
                                  : fwd_sbox(IN_state[8*k +: 8]);
`else
         w_sub[8*k +: 8] = fwd_sbox(IN_state[8*k +: 8]);
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_state <= '0;
      end else begin
         r_valid <= IN_valid;
         // Result is held when no new state arrives.
         if (IN_valid) r_state <= w_sub;
      end
   end

   assign OUT_valid = r_valid;
   assign OUT_state = r_state;

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes: reset, known S-box vectors, back-to-back
// streaming, hold behaviour, asynchronous mid-stream reset and (when built with
// SUBBYTES_INV_EN) the inverse S-box.

module tb_sub_bytes;

   logic         clk;
   logic         reset_n;
   logic         IN_valid;
   logic [127:0] IN_state;
`ifdef SUBBYTES_INV_EN
   logic         IN_inv;
`endif
   logic         OUT_valid;
   logic [127:0] OUT_state;

   sub_bytes dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .IN_valid  (IN_valid),
      .IN_state  (IN_state),
`ifdef SUBBYTES_INV_EN
      .IN_inv    (IN_inv),
`endif
      .OUT_valid (OUT_valid),
      .OUT_state (OUT_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] st;
      logic [127:0] ex;
   } vec_t;

   vec_t         tbl [6];
   logic [127:0] exp_q [$];
   logic [127:0] last_exp;
   int           n_checks;
   int           n_errors;
   int           valid_cnt;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Compare outputs sampled just after a rising edge against the scoreboard.
   task automatic check_out(input logic exp_v, input string nm);
      logic [127:0] e;
      chk({nm, "_valid"}, {127'd0, OUT_valid}, {127'd0, exp_v});
      if (OUT_valid === 1'b1) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            chk({nm, "_unexpected"}, OUT_state, 128'hx);
         end else begin
            e = exp_q.pop_front();
            chk({nm, "_state"}, OUT_state, e);
            last_exp = e;
         end
      end else begin
         chk({nm, "_hold"}, OUT_state, last_exp);
      end
   endtask

   // One cycle: drive at the falling edge, check just after the rising edge.
   task automatic step(input logic v, input logic [127:0] st, input logic [127:0] ex,
                       input logic inv, input string nm);
      @(negedge clk);
      IN_valid = v;
      IN_state = st;
`ifdef SUBBYTES_INV_EN
      IN_inv   = inv;
`endif
      if (v) exp_q.push_back(ex);
      @(posedge clk);
      #1;
      check_out(v, nm);
   endtask

`ifdef SUBBYTES_INV_EN
   logic [127:0] orig [16];
   logic [127:0] fwd  [16];
`endif

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      valid_cnt = 0;
      last_exp  = '0;

      tbl[0] = '{st: 128'hEA835CF0_0445332D_655D98AD_8596B0C5, ex: 128'h87EC4A8C_F26EC3D8_4D4C4695_9790E7A6};
      tbl[1] = '{st: 128'h0,                                  ex: {16{8'h63}}};
      tbl[2] = '{st: {16{8'hFF}},                             ex: {16{8'h16}}};
      tbl[3] = '{st: {16{8'h53}},                             ex: {16{8'hED}}};
      tbl[4] = '{st: 128'h0F0E0D0C_0B0A0908_07060504_03020100, ex: 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63};
      tbl[5] = '{st: 128'hF0E0D0C0_B0A09080_70605040_30201000, ex: 128'h8CE170BA_E7E060CD_51D05309_04B7CA63};

      // Reset for 5 cycles with a valid input present: it must be ignored.
      reset_n  = 1'b0;
      IN_valid = 1'b1;
      IN_state = tbl[0].st;
`ifdef SUBBYTES_INV_EN
      IN_inv   = 1'b0;
`endif
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("reset_valid", {127'd0, OUT_valid}, 128'd0);
         chk("reset_state", OUT_state, 128'd0);
      end
      @(negedge clk);
      IN_valid = 1'b0;
      reset_n  = 1'b1;
      step(1'b0, 128'h0, 128'h0, 1'b0, "post_reset_idle0");
      step(1'b0, 128'h0, 128'h0, 1'b0, "post_reset_idle1");

      // Known vectors, back-to-back.
      for (int i = 0; i < 6; i++) step(1'b1, tbl[i].st, tbl[i].ex, 1'b0, "vec");
      step(1'b0, 128'h0, 128'h0, 1'b0, "vec_idle0");
      step(1'b0, 128'h0, 128'h0, 1'b0, "vec_idle1");
      chk("hold_last_vec", OUT_state, tbl[5].ex);

      // Three consecutive states then idle: exactly three valid cycles, in order.
      valid_cnt = 0;
      for (int i = 1; i < 4; i++) step(1'b1, tbl[i].st, tbl[i].ex, 1'b0, "burst");
      for (int i = 0; i < 3; i++) step(1'b0, 128'h0, 128'h0, 1'b0, "burst_idle");
      chk("burst_valid_count", 128'(valid_cnt), 128'd3);
      chk("burst_hold", OUT_state, tbl[3].ex);

      // Asynchronous reset between edges while OUT_valid is high.
      step(1'b1, tbl[0].st, tbl[0].ex, 1'b0, "pre_areset");
      @(negedge clk);
      IN_valid = 1'b1;            // pending state that reset must discard
      IN_state = tbl[2].st;
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_valid_immediate", {127'd0, OUT_valid}, 128'd0);
      chk("areset_state_immediate", OUT_state, 128'd0);
      last_exp = '0;
      @(posedge clk);
      #1;
      chk("areset_held_valid", {127'd0, OUT_valid}, 128'd0);
      chk("areset_held_state", OUT_state, 128'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      IN_valid = 1'b0;
      step(1'b0, 128'h0, 128'h0, 1'b0, "post_areset_idle");
      step(1'b1, tbl[4].st, tbl[4].ex, 1'b0, "post_areset_vec");

`ifdef SUBBYTES_INV_EN
      // Inverse of the reference vector returns the original state.
      step(1'b1, tbl[0].ex, tbl[0].st, 1'b1, "inv_ref");
      step(1'b1, {16{8'h63}}, 128'h0, 1'b1, "inv_63");

      // All 256 byte values: forward, capture, then inverse back to the original.
      for (int g = 0; g < 16; g++) begin
         for (int k = 0; k < 16; k++) orig[g][8*k +: 8] = 8'(16*g + k);
         @(negedge clk);
         IN_valid = 1'b1;
         IN_state = orig[g];
         IN_inv   = 1'b0;
         @(posedge clk);
         #1;
         chk("fwd_capture_valid", {127'd0, OUT_valid}, 128'd1);
         fwd[g]   = OUT_state;
         last_exp = OUT_state;
      end
      for (int g = 0; g < 16; g++) step(1'b1, fwd[g], orig[g], 1'b1, "roundtrip");
      step(1'b0, 128'h0, 128'h0, 1'b0, "inv_idle");
`endif

      chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
